// File: rtl/goofy_seq_pkg.sv
// goofy_seq_pkg: shared definitions for the Goofy fetch/microcode sequencer.
//   - seq_state_e   : FSM state encoding, also driven onto the sequencer's `state` output
//   - MC_FINISH_BIT : microword bit that ends the current instruction
//   - MC_HALT_BIT   : microword bit that halts the core
//   - op_count()    : number of operand bytes that follow an iop byte
// Optional build macro GOOFY_SEQ_SINGLE_STEP_EN adds the PAUSE state.
package goofy_seq_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFIop  = 3'd1,
    StFOp0  = 3'd2,
    StFOp1  = 3'd3,
    StExec  = 3'd4,
`ifdef GOOFY_SEQ_SINGLE_STEP_EN
    StHalt  = 3'd5,
    StPause = 3'd6
`else
    StHalt  = 3'd5
`endif
  } seq_state_e;

  localparam int unsigned MC_FINISH_BIT = 0;
  localparam int unsigned MC_HALT_BIT   = 1;

  // iop[7:6] gives the operand count; the encoding 3 is treated as 2.
  function automatic logic [1:0] op_count(input logic [7:0] iop_byte);
    return (iop_byte[7:6] == 2'd3) ? 2'd2 : iop_byte[7:6];
  endfunction

endpackage

// File: rtl/goofy_mc_sequencer_if.sv
// goofy_mc_sequencer_if: groups the program-memory fetch port and the microcode/datapath port.
//   fetch_req  : sequencer -> memory, read request
//   fetch_addr : sequencer -> memory, read address (= rip)
//   fetch_ack  : memory -> sequencer, fetch_data valid this cycle
//   fetch_data : memory -> sequencer, program byte
//   mc_addr    : sequencer -> ROM, {iop, step}
//   mc_word    : ROM -> sequencer/datapath, microword for mc_addr
//   mc_valid   : sequencer -> datapath, mc_word is executed this cycle
//   mc_stall   : datapath -> sequencer, hold the current microstep
// Modports: master = sequencer side, slave = memory/ROM/datapath side.
interface goofy_mc_sequencer_if #(
  parameter int unsigned RIP_W     = 8,
  parameter int unsigned STEP_W    = 4,
  parameter int unsigned MC_WORD_W = 16
) ();

  logic                 fetch_req;
  logic [RIP_W-1:0]     fetch_addr;
  logic                 fetch_ack;
  logic [7:0]           fetch_data;
  logic [8+STEP_W-1:0]  mc_addr;
  logic [MC_WORD_W-1:0] mc_word;
  logic                 mc_valid;
  logic                 mc_stall;

  modport master (
    output fetch_req,
    output fetch_addr,
    input  fetch_ack,
    input  fetch_data,
    output mc_addr,
    input  mc_word,
    output mc_valid,
    input  mc_stall
  );

  modport slave (
    input  fetch_req,
    input  fetch_addr,
    output fetch_ack,
    output fetch_data,
    input  mc_addr,
    output mc_word,
    input  mc_valid,
    output mc_stall
  );

endinterface

// File: rtl/goofy_fetch_unit.sv
// goofy_fetch_unit: instruction byte fetch and instruction pointer for the Goofy sequencer.
// Ports:
//   clk, res       : clock, asynchronous active-low reset
//   state_i        : sequencer state (fetch activity is keyed off the F_* states)
//   fetch_ack_i    : memory data valid; ignored unless a request is outstanding
//   fetch_data_i   : program byte
//   rip_load_i     : jump request, honoured only in EXEC
//   rip_value_i    : jump target
//   fetch_req_o    : read request (high throughout every F_* state)
//   byte_done_o    : a byte was accepted this cycle
//   n_ops_o        : operand count of the current instruction (of the incoming byte in F_IOP)
//   rip_o          : instruction pointer, also the fetch address
//   iop_o/op0_o/op1_o : latched instruction bytes
module goofy_fetch_unit
  import goofy_seq_pkg::*;
#(
  parameter int unsigned RIP_W = 8
) (
  input  logic             clk,
  input  logic             res,
  input  seq_state_e       state_i,
  input  logic             fetch_ack_i,
  input  logic [7:0]       fetch_data_i,
  input  logic             rip_load_i,
  input  logic [RIP_W-1:0] rip_value_i,
  output logic             fetch_req_o,
  output logic             byte_done_o,
  output logic [1:0]       n_ops_o,
  output logic [RIP_W-1:0] rip_o,
  output logic [7:0]       iop_o,
  output logic [7:0]       op0_o,
  output logic [7:0]       op1_o
);

  logic [RIP_W-1:0] rip_q, rip_d;
  logic [7:0]       iop_q, iop_d;
  logic [7:0]       op0_q, op0_d;
  logic [7:0]       op1_q, op1_d;
  logic [1:0]       new_ops;

  assign fetch_req_o = (state_i == StFIop) || (state_i == StFOp0) || (state_i == StFOp1);
  assign byte_done_o = fetch_req_o && fetch_ack_i;
  assign new_ops     = op_count(fetch_data_i);
  // In F_IOP the transition depends on the byte being latched, not on the stale iop.
  assign n_ops_o     = (state_i == StFIop) ? new_ops : op_count(iop_q);

  always_comb begin
    rip_d = rip_q;
    iop_d = iop_q;
    op0_d = op0_q;
    op1_d = op1_q;
    if (byte_done_o) begin
      rip_d = rip_q + RIP_W'(1);
      case (state_i)
        StFIop: begin
          iop_d = fetch_data_i;
          if (new_ops == 2'd0) begin
            op0_d = 8'h00;
          end
          if (new_ops != 2'd2) begin
            op1_d = 8'h00;
          end
        end
        StFOp0:  op0_d = fetch_data_i;
        StFOp1:  op1_d = fetch_data_i;
        default: ;
      endcase
    end else if ((state_i == StExec) && rip_load_i) begin
      rip_d = rip_value_i;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      rip_q <= '0;
      iop_q <= 8'h00;
      op0_q <= 8'h00;
      op1_q <= 8'h00;
    end else begin
      rip_q <= rip_d;
      iop_q <= iop_d;
      op0_q <= op0_d;
      op1_q <= op1_d;
    end
  end

  assign rip_o = rip_q;
  assign iop_o = iop_q;
  assign op0_o = op0_q;
  assign op1_o = op1_q;

endmodule

// File: rtl/goofy_mc_sequencer.sv
// goofy_mc_sequencer: fetch/microcode sequencer of the Goofy core.
// Fetches iop plus 0-2 operand bytes, then steps the microcode ROM address {iop, step} until the
// microword signals finish (next fetch) or halt. A runaway instruction that uses every step
// without finishing halts the core with fault set.
// Ports:
//   clk, res   : clock, asynchronous active-low reset
//   bus        : fetch and microcode port (goofy_mc_sequencer_if.master)
//   rip_load   : jump, rip <= rip_value; honoured in EXEC only (stalled or not)
//   rip_value  : jump target
//   step_go    : (GOOFY_SEQ_SINGLE_STEP_EN only) leave PAUSE and fetch the next instruction
//   iop/op0/op1: latched instruction bytes
//   rip        : instruction pointer
//   state      : current FSM state encoding
//   hlt        : core halted
//   fault      : microstep overflow
// Build macro: GOOFY_SEQ_SINGLE_STEP_EN enables single-step mode (PAUSE after each instruction).
module goofy_mc_sequencer
  import goofy_seq_pkg::*;
#(
  parameter int unsigned RIP_W     = 8,
  parameter int unsigned STEP_W    = 4,
  parameter int unsigned MC_WORD_W = 16
) (
  input  logic                   clk,
  input  logic                   res,
  goofy_mc_sequencer_if.master   bus,
  input  logic                   rip_load,
  input  logic [RIP_W-1:0]       rip_value,
`ifdef GOOFY_SEQ_SINGLE_STEP_EN
  input  logic                   step_go,
`endif
  output logic [7:0]             iop,
  output logic [7:0]             op0,
  output logic [7:0]             op1,
  output logic [RIP_W-1:0]       rip,
  output logic [2:0]             state,
  output logic                   hlt,
  output logic                   fault
);

`ifdef GOOFY_SEQ_SINGLE_STEP_EN
  localparam seq_state_e AfterFinish = StPause;
`else
  localparam seq_state_e AfterFinish = StFIop;
`endif

  seq_state_e        state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              fault_q, fault_d;
  logic              mc_valid;
  logic              fetch_req;
  logic              byte_done;
  logic [1:0]        n_ops;

  // Bits above halt/finish belong to the datapath.
  logic unused_mc_word;
  assign unused_mc_word = ^bus.mc_word[MC_WORD_W-1:2];

  goofy_fetch_unit #(
    .RIP_W (RIP_W)
  ) u_fetch (
    .clk          (clk),
    .res          (res),
    .state_i      (state_q),
    .fetch_ack_i  (bus.fetch_ack),
    .fetch_data_i (bus.fetch_data),
    .rip_load_i   (rip_load),
    .rip_value_i  (rip_value),
    .fetch_req_o  (fetch_req),
    .byte_done_o  (byte_done),
    .n_ops_o      (n_ops),
    .rip_o        (rip),
    .iop_o        (iop),
    .op0_o        (op0),
    .op1_o        (op1)
  );

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    fault_d  = fault_q;
    mc_valid = 1'b0;
    case (state_q)
      StIdle: state_d = StFIop;
      StFIop: begin
        if (byte_done) begin
          state_d = (n_ops != 2'd0) ? StFOp0 : StExec;
        end
      end
      StFOp0: begin
        if (byte_done) begin
          state_d = (n_ops == 2'd2) ? StFOp1 : StExec;
        end
      end
      StFOp1: begin
        if (byte_done) begin
          state_d = StExec;
        end
      end
      StExec: begin
        // A stalled cycle ignores mc_word entirely and keeps step/state.
        mc_valid = !bus.mc_stall;
        if (!bus.mc_stall) begin
          if (bus.mc_word[MC_HALT_BIT]) begin
            state_d = StHalt;
          end else if (bus.mc_word[MC_FINISH_BIT]) begin
            state_d = AfterFinish;
            step_d  = '0;
          end else if (step_q == {STEP_W{1'b1}}) begin
            state_d = StHalt;
            fault_d = 1'b1;
          end else begin
            step_d = step_q + STEP_W'(1);
          end
        end
      end
      StHalt: ;
`ifdef GOOFY_SEQ_SINGLE_STEP_EN
      StPause: begin
        if (step_go) begin
          state_d = StFIop;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= StIdle;
      step_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      fault_q <= fault_d;
    end
  end

  assign bus.fetch_req  = fetch_req;
  assign bus.fetch_addr = rip;
  assign bus.mc_addr    = {iop, step_q};
  assign bus.mc_valid   = mc_valid;

  assign state = state_q;
  assign hlt   = (state_q == StHalt);
  assign fault = fault_q;

endmodule
